fifo_drain_serializer: RTL and testbench

FIFO_DRAIN_SERIALIZER -- requirements
Module: fifo_drain_serializer

---
 rtl/fifo_drain_serializer_if.sv | 40 ++++
 rtl/fifo_drain_serializer.sv | 94 +++++++++
 tb/tb_fifo_drain_serializer.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_drain_serializer_if.sv
// Handshake bundle for the FIFO drain serializer:
// FIFO read side, beat stream side and word counter.
interface fifo_drain_serializer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BEAT_WIDTH = 8
);
  logic                  en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd;
  logic                  m_valid;
  logic                  m_ready;
  logic [BEAT_WIDTH-1:0] m_data;
  logic                  m_last;
  logic [15:0]           word_count;

  modport master (
    input  en,
    input  fifo_empty,
    input  fifo_dout,
    input  m_ready,
    output fifo_rd,
    output m_valid,
    output m_data,
    output m_last,
    output word_count
  );

  modport slave (
    output en,
    output fifo_empty,
    output fifo_dout,
    output m_ready,
    input  fifo_rd,
    input  m_valid,
    input  m_data,
    input  m_last,
    input  word_count
  );
endinterface

// File: rtl/fifo_drain_serializer.sv
// Pops words from a synchronous FIFO and emits them
// LSB beat first over a valid/ready stream.
module fifo_drain_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int BEAT_WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst,
  fifo_drain_serializer_if.master bus
);
  localparam int BEATS = DATA_WIDTH / BEAT_WIDTH;
  localparam int IW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);

  generate
    if (DATA_WIDTH % BEAT_WIDTH != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of BEAT_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    CAPT,
    SEND
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_sr;
  logic [IW-1:0]         r_idx;
  logic                  r_valid;
  logic                  r_last;
  logic [BEAT_WIDTH-1:0] r_data;
  logic [15:0]           r_cnt;

  logic                  w_rd;
  logic [DATA_WIDTH-1:0] w_sr_nxt;
  logic [IW-1:0]         w_idx_nxt;

  // Pop is combinational so the FIFO sees it in the IDLE cycle.
  assign w_rd = rst && (r_state == IDLE)
             && bus.en && !bus.fifo_empty;

  assign w_sr_nxt  = r_sr >> BEAT_WIDTH;
  assign w_idx_nxt = r_idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rd) r_state <= CAPT;
        end
        CAPT: begin
          r_sr    <= bus.fifo_dout;
          r_idx   <= '0;
          r_valid <= 1'b1;
          r_data  <= bus.fifo_dout[BEAT_WIDTH-1:0];
          r_last  <= (BEATS == 1);
          r_state <= SEND;
        end
        SEND: begin
          if (bus.m_ready) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_data  <= '0;
              r_cnt   <= r_cnt + 16'd1;
              r_state <= IDLE;
            end else begin
              r_sr   <= w_sr_nxt;
              r_idx  <= w_idx_nxt;
              r_data <= w_sr_nxt[BEAT_WIDTH-1:0];
              r_last <= (w_idx_nxt == LAST_IDX);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.fifo_rd    = w_rd;
  assign bus.m_valid    = r_valid;
  assign bus.m_data     = r_data;
  assign bus.m_last     = r_last;
  assign bus.word_count = r_cnt;
endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Scoreboard bench for the FIFO drain serializer:
// FIFO model, beat monitor and per-scenario tasks.
module tb_fifo_drain_serializer;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int BEATS = DW / BW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_drain_serializer_if #(
    .DATA_WIDTH(DW),
    .BEAT_WIDTH(BW)
  ) bus ();

  fifo_drain_serializer #(
    .DATA_WIDTH(DW),
    .BEAT_WIDTH(BW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;

  logic [DW-1:0] mem[$];
  logic [BW:0]   exp_q[$];
  int            rd_cyc[$];
  int            beat_cyc[$];

  bit            prev_stall = 1'b0;
  logic [BW-1:0] prev_data = '0;
  logic [BW:0]   e;

  // Synchronous FIFO: data one edge after the pop.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_rd && mem.size() > 0)
      bus.fifo_dout <= mem.pop_front();
  end

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.fifo_rd) begin
        rd_cnt++;
        rd_cyc.push_back(cyc);
        checks++;
        if (mem.size() == 0) begin
          errors++;
          $display("FAIL rd_on_empty fifo_rd=1 required 0");
        end
      end
      if (prev_stall) begin
        checks++;
        if (bus.m_valid !== 1'b1 ||
            bus.m_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold valid=%0b data=%h required valid=1 data=%h",
                   bus.m_valid, bus.m_data, prev_data);
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        checks++;
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_extra data=%h required none",
                   bus.m_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.m_last, bus.m_data} !== e) begin
            errors++;
            $display("FAIL beat last=%0b data=%h required last=%0b data=%h",
                     bus.m_last, bus.m_data, e[BW], e[BW-1:0]);
          end
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end
    bus.fifo_empty = (mem.size() == 0);
  end

  task automatic push(input logic [DW-1:0] w);
    mem.push_back(w);
    bus.fifo_empty = 1'b0;
    for (int k = 0; k < BEATS; k++)
      exp_q.push_back({k == BEATS - 1, w[k*BW +: BW]});
  endtask

  task automatic wait_drain(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !bus.m_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit ok;
    rst = 1'b0;
    bus.en = 1'b1;
    bus.m_ready = 1'b1;
    push(32'h0BADF00D);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.fifo_rd !== 1'b0 || bus.m_valid !== 1'b0 ||
          bus.m_data !== '0 || bus.m_last !== 1'b0 ||
          bus.word_count !== 16'd0) begin
        errors++;
        $display("FAIL reset_state rd=%0b v=%0b d=%h l=%0b wc=%0d required all 0",
                 bus.fifo_rd, bus.m_valid, bus.m_data,
                 bus.m_last, bus.word_count);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.fifo_rd !== 1'b1) begin
      errors++;
      $display("FAIL release_pop fifo_rd=%0b required 1",
               bus.fifo_rd);
    end
    wait_drain(40, ok);
    checks++;
    if (!ok || bus.word_count !== 16'd1) begin
      errors++;
      $display("FAIL release_word ok=%0b wc=%0d required ok=1 wc=1",
               ok, bus.word_count);
    end
  endtask

  task automatic test_single;
    bit ok;
    int rd0;
    rd0 = rd_cnt;
    beat_cyc.delete();
    rd_cyc.delete();
    push(32'hA1B2C3D4);
    wait_drain(40, ok);
    checks++;
    if (!ok || bus.word_count !== 16'd2) begin
      errors++;
      $display("FAIL single_wc ok=%0b wc=%0d required ok=1 wc=2",
               ok, bus.word_count);
    end
    checks++;
    if (rd_cnt - rd0 != 1) begin
      errors++;
      $display("FAIL single_rd pulses=%0d required 1",
               rd_cnt - rd0);
    end
    checks++;
    if (beat_cyc.size() != 4 ||
        beat_cyc[3] - beat_cyc[0] != 3) begin
      errors++;
      $display("FAIL single_consec beats=%0d required 4 consecutive",
               beat_cyc.size());
    end
    checks++;
    if (rd_cyc.size() != 1 || beat_cyc.size() == 0 ||
        beat_cyc[0] - rd_cyc[0] != 2) begin
      errors++;
      $display("FAIL single_latency got other required 2 cycles");
    end
  endtask

  task automatic test_stall;
    bit ok;
    logic [6:0] pat;
    pat = 7'b1011001;
    bus.m_ready = 1'b0;
    push(32'hA1B2C3D4);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_start valid=0 required 1");
    end
    for (int i = 0; i < 7; i++) begin
      bus.m_ready = pat[i];
      @(posedge clk); #1;
    end
    bus.m_ready = 1'b1;
    checks++;
    if (exp_q.size() != 0 || bus.word_count !== 16'd3) begin
      errors++;
      $display("FAIL stall_done left=%0d wc=%0d required 0 and 3",
               exp_q.size(), bus.word_count);
    end
    wait_drain(10, ok);
  endtask

  task automatic test_back_to_back;
    bit ok;
    rd_cyc.delete();
    push(32'h00000001);
    push(32'h11223344);
    push(32'hFFFFFFFF);
    wait_drain(60, ok);
    checks++;
    if (!ok || bus.word_count !== 16'd6) begin
      errors++;
      $display("FAIL b2b_wc ok=%0b wc=%0d required ok=1 wc=6",
               ok, bus.word_count);
    end
    checks++;
    if (rd_cyc.size() != 3) begin
      errors++;
      $display("FAIL b2b_pulses got=%0d required 3",
               rd_cyc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (rd_cyc[i] - rd_cyc[i-1] != 6) begin
          errors++;
          $display("FAIL b2b_spacing got=%0d required 6",
                   rd_cyc[i] - rd_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_empty;
    bus.en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.fifo_rd !== 1'b0 || bus.m_valid !== 1'b0) begin
        errors++;
        $display("FAIL empty_idle rd=%0b v=%0b required 0 0",
                 bus.fifo_rd, bus.m_valid);
      end
    end
  endtask

  task automatic test_en_drop;
    bit ok;
    push(32'hCAFEBABE);
    push(32'h12345678);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() <= 7) begin
        ok = 1'b1;
        break;
      end
    end
    bus.en = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL endrop_start no beat required one");
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 4 && !bus.m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || bus.word_count !== 16'd7) begin
      errors++;
      $display("FAIL endrop_finish ok=%0b wc=%0d required ok=1 wc=7",
               ok, bus.word_count);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.fifo_rd !== 1'b0 || bus.m_valid !== 1'b0) begin
        errors++;
        $display("FAIL endrop_hold rd=%0b v=%0b required 0 0",
                 bus.fifo_rd, bus.m_valid);
      end
    end
    bus.en = 1'b1;
    wait_drain(40, ok);
    checks++;
    if (!ok || bus.word_count !== 16'd8) begin
      errors++;
      $display("FAIL endrop_resume ok=%0b wc=%0d required ok=1 wc=8",
               ok, bus.word_count);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    push(32'h55667788);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 2) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || bus.m_data !== 8'h66) begin
      errors++;
      $display("FAIL rstmid_beat3 ok=%0b data=%h required ok=1 data=66",
               ok, bus.m_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 ||
        bus.m_data !== '0) begin
      errors++;
      $display("FAIL rstmid_async v=%0b l=%0b d=%h required 0 0 00",
               bus.m_valid, bus.m_last, bus.m_data);
    end
    exp_q.delete();
    @(posedge clk); #1;
    checks++;
    if (bus.word_count !== 16'd0 || bus.fifo_rd !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_hold wc=%0d rd=%0b required 0 0",
               bus.word_count, bus.fifo_rd);
    end
    rst = 1'b1;
    push(32'h99AABBCC);
    wait_drain(40, ok);
    checks++;
    if (!ok || bus.word_count !== 16'd1) begin
      errors++;
      $display("FAIL rstmid_restart ok=%0b wc=%0d required ok=1 wc=1",
               ok, bus.word_count);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.en = 1'b0;
    bus.m_ready = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_dout = '0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_empty();
    test_en_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
